// File: rtl/kaly_sbox_engine.sv
// kaly_sbox_engine: run-time programmable byte S-box with a self-built inverse.
// Substitutes LANES bytes per cycle of an NBYTES block under valid/ready.
module kaly_sbox_engine #(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tbl_we,
  input  logic [7:0]          tbl_addr,
  input  logic [7:0]          tbl_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NBYTES*8-1:0] in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NBYTES*8-1:0] out_data,
  output logic                busy
);
  localparam int STEPS = (LANES > 0) ? NBYTES / LANES : 1;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (NBYTES < 1 || LANES < 1 || LANES > NBYTES ||
      (NBYTES % LANES) != 0) begin : g_bad_cfg
    $error("kaly_sbox_engine: LANES must divide NBYTES");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]          t_q  [256];
  logic [7:0]          ti_q [256];
  logic [NBYTES*8-1:0] work_q;
  logic                mode_q;
  logic [CW-1:0]       cnt_q;
  logic [7:0]          sub_b [LANES];

  assign in_ready  = (state_q == S_IDLE) & ~rst & ~tbl_we;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = work_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid && in_ready) state_d = S_SUB;
      S_SUB:  if (cnt_q == LAST) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // lane l looks at byte cnt*LANES+l of the work block
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sub_b[l] = mode_q
        ? ti_q[work_q[(int'(cnt_q) * LANES + l) * 8 +: 8]]
        : t_q[work_q[(int'(cnt_q) * LANES + l) * 8 +: 8]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      for (int a = 0; a < 256; a++) begin
        t_q[a]  <= 8'(a);
        ti_q[a] <= 8'(a);
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // table write has priority over block accept
          if (tbl_we) begin
            t_q[tbl_addr]  <= tbl_data;
            ti_q[tbl_data] <= tbl_addr;
          end else if (in_valid) begin
            work_q <= in_data;
            mode_q <= in_inv;
            cnt_q  <= '0;
          end
        end
        S_SUB: begin
          for (int l = 0; l < LANES; l++) begin
            work_q[(int'(cnt_q) * LANES + l) * 8 +: 8] <= sub_b[l];
          end
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kaly_sbox_engine.sv
// tb_kaly_sbox_engine: directed + random checks against a table-level model.
// Also sweeps (16,1), (16,16), (1,1) configurations in parallel.
module tb_kaly_sbox_engine;
  localparam int NB = 16;
  localparam int W  = NB * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, tbl_we;
  logic [7:0]   tbl_addr, tbl_data;
  logic         in_valid, in_ready, in_inv;
  logic         out_valid, out_ready, busy;
  logic [W-1:0] in_data, out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int sweep_done = 0;

  logic [7:0] tm [256];
  logic [7:0] ti [256];

  kaly_sbox_engine #(.NBYTES(NB), .LANES(4)) u_dut (
    .clk(clk), .rst(rst),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 256; a++) begin
      tm[a] = 8'(a);
      ti[a] = 8'(a);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d,
                                         input logic inv);
    logic [W-1:0] r;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = inv ? ti[d[8*i +: 8]] : tm[d[8*i +: 8]];
    return r;
  endfunction

  // all tasks start and end on a falling edge
  task automatic tbl_wr(input logic [7:0] a, input logic [7:0] v);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = v;
    @(negedge clk);
    tbl_we = 1'b0;
    tm[a] = v;
    ti[v] = a;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic inv,
                      output int lat);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_wait", 128'(n < 50), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ov_drop", 128'(out_valid), 128'd0);
    chk("ir_back", 128'(in_ready), 128'd1);
  endtask

  task automatic xfer(input string tag, input logic [W-1:0] d,
                      input logic inv, input logic [W-1:0] exp);
    int lat;
    send(d, inv, lat);
    chk({tag, "_lat"}, 128'(lat), 128'(NB / 4));
    chk({tag, "_data"}, out_data, exp);
    release_out();
  endtask

  initial begin
    logic [W-1:0] d, e, cap;
    int lat, n;
    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ov", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_od", out_data, 128'd0);
    chk("rst_ir", 128'(in_ready), 128'd0);
    rst = 1'b0;
    #1 chk("post_rst_ir", 128'(in_ready), 128'd1);
    @(negedge clk);

    xfer("ident", 128'h0F0E0D0C0B0A09080706050403020100, 1'b0,
         128'h0F0E0D0C0B0A09080706050403020100);

    for (int a = 0; a < 256; a++) tbl_wr(8'(a), 8'(a + 1));
    xfer("perm_ff", {16{8'hFF}}, 1'b0, {16{8'h00}});
    xfer("perm_inv", {16{8'h00}}, 1'b1, {16{8'hFF}});
    for (int i = 0; i < NB; i++) begin
      d[8*i +: 8] = 8'(i);
      e[8*i +: 8] = 8'(i + 1);
    end
    xfer("perm_idx", d, 1'b0, e);

    d = {$urandom, $urandom, $urandom, $urandom};
    e = model(d, 1'b0);
    send(d, 1'b0, lat);
    chk("bp_lat", 128'(lat), 128'(NB / 4));
    cap = out_data;
    chk("bp_data", cap, e);
    repeat (10) begin
      @(negedge clk);
      chk("bp_ov", 128'(out_valid), 128'd1);
      chk("bp_od", out_data, cap);
      chk("bp_ir", 128'(in_ready), 128'd0);
      chk("bp_busy", 128'(busy), 128'd1);
    end
    release_out();

    in_valid = 1'b1; in_data = '0; in_inv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("subwe_busy", 128'(busy), 128'd1);
    tbl_we = 1'b1; tbl_addr = 8'h00; tbl_data = 8'h55;
    @(negedge clk);
    tbl_we = 1'b0;
    wait_out(lat);
    chk("subwe_blk", out_data, {16{8'h01}});
    release_out();
    xfer("subwe", {16{8'h00}}, 1'b0, {16{8'h01}});

    in_valid = 1'b1; in_data = {120'h0, 8'h10}; in_inv = 1'b0;
    tbl_we = 1'b1; tbl_addr = 8'h10; tbl_data = 8'hAB;
    #1 chk("prio_ir", 128'(in_ready), 128'd0);
    @(negedge clk);
    tbl_we = 1'b0;
    tm[8'h10] = 8'hAB;
    ti[8'hAB] = 8'h10;
    #1 chk("prio_ir2", 128'(in_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk("prio_lat", 128'(lat), 128'(NB / 4));
    chk("prio_b0", 128'(out_data[7:0]), 128'h0AB);
    release_out();

    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ov", 128'(out_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    model_reset();
    #1 chk("mid_rst_ir", 128'(in_ready), 128'd1);
    @(negedge clk);
    d = {$urandom, $urandom, $urandom, $urandom};
    xfer("post_rst_id", d, 1'($urandom), d);

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 3)) tbl_wr(8'($urandom), 8'($urandom));
      d = {$urandom, $urandom, $urandom, $urandom};
      in_inv = 1'($urandom);
      xfer("rnd", d, in_inv, model(d, in_inv));
    end

    n = 0;
    while (sweep_done < 3 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_done", 128'(sweep_done), 128'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int SNB = (g == 2) ? 1 : 16;
    localparam int SLN = (g == 0) ? 1 : ((g == 1) ? 16 : 1);
    localparam int SST = SNB / SLN;

    logic             s_rst, s_we, s_iv, s_ir, s_inv;
    logic             s_ov, s_or, s_busy;
    logic [7:0]       s_a, s_v;
    logic [SNB*8-1:0] s_id, s_od;

    kaly_sbox_engine #(.NBYTES(SNB), .LANES(SLN)) u_sw (
      .clk(clk), .rst(s_rst),
      .tbl_we(s_we), .tbl_addr(s_a), .tbl_data(s_v),
      .in_valid(s_iv), .in_ready(s_ir),
      .in_data(s_id), .in_inv(s_inv),
      .out_valid(s_ov), .out_ready(s_or),
      .out_data(s_od), .busy(s_busy)
    );

    initial begin
      logic [7:0] sm [256];
      logic [7:0] si [256];
      logic [7:0] mul, add;
      logic [SNB*8-1:0] d, e;
      int lat;
      s_rst = 1'b1; s_we = 1'b0; s_a = '0; s_v = '0;
      s_iv = 1'b0; s_inv = 1'b0; s_or = 1'b0; s_id = '0;
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      mul = 8'($urandom) | 8'h01;
      add = 8'($urandom);
      for (int a = 0; a < 256; a++) begin
        s_we = 1'b1; s_a = 8'(a); s_v = 8'(a) * mul + add;
        sm[s_a] = s_v;
        si[s_v] = s_a;
        @(negedge clk);
      end
      s_we = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
        for (int i = 0; i < SNB; i++) d[8*i +: 8] = 8'($urandom);
        s_inv = 1'($urandom);
        for (int i = 0; i < SNB; i++)
          e[8*i +: 8] = s_inv ? si[d[8*i +: 8]] : sm[d[8*i +: 8]];
        s_iv = 1'b1; s_id = d;
        chk($sformatf("sw%0d_ir", g), 128'(s_ir), 128'd1);
        @(posedge clk);
        @(negedge clk);
        s_iv = 1'b0;
        lat = 0;
        while (!s_ov && lat < 100) begin
          @(negedge clk);
          lat++;
        end
        chk($sformatf("sw%0d_lat", g), 128'(lat), 128'(SST));
        chk($sformatf("sw%0d_data", g), 128'(s_od), 128'(e));
        s_or = 1'b1;
        @(negedge clk);
        s_or = 1'b0;
      end
      sweep_done++;
    end
  end
endmodule
